// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, two-entry skid buffer,
// synchronous flush that inserts bubbles, and a saturating stall counter.
module pipe_stage_skid #(
    parameter int DATA_W  = 101,
    parameter int CTRL_W  = 6,
    parameter int STALL_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    input  logic [CTRL_W-1:0]  in_ctrl,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic [CTRL_W-1:0]  out_ctrl,
    output logic [1:0]         occupancy,
    output logic [STALL_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam logic [STALL_W-1:0] STALL_MAX = '1;

    state_t            state;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] skid_ctrl;
    logic              accept;
    logic              deq;

    assign accept = in_valid & in_ready & ~flush;
    assign deq    = out_valid & out_ready;

    // in_ready, out_valid and occupancy are registered alongside the state so
    // that no combinational path runs from out_ready back to in_ready.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ctrl  <= '0;
            skid_data <= '0;
            skid_ctrl <= '0;
            occupancy <= 2'd0;
        end else if (flush) begin
            // out_data intentionally holds; only control is scrubbed to a bubble.
            state     <= EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_ctrl  <= '0;
            occupancy <= 2'd0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state     <= BUSY;
                        out_valid <= 1'b1;
                        out_data  <= in_data;
                        out_ctrl  <= in_ctrl;
                        occupancy <= 2'd1;
                    end
                end
                BUSY: begin
                    if (accept && deq) begin
                        out_data <= in_data;
                        out_ctrl <= in_ctrl;
                    end else if (accept) begin
                        state     <= FULL;
                        skid_data <= in_data;
                        skid_ctrl <= in_ctrl;
                        in_ready  <= 1'b0;
                        occupancy <= 2'd2;
                    end else if (deq) begin
                        state     <= EMPTY;
                        out_valid <= 1'b0;
                        out_ctrl  <= '0;
                        occupancy <= 2'd0;
                    end
                end
                FULL: begin
                    if (deq) begin
                        state     <= BUSY;
                        out_data  <= skid_data;
                        out_ctrl  <= skid_ctrl;
                        in_ready  <= 1'b1;
                        occupancy <= 2'd1;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    out_ctrl  <= '0;
                    occupancy <= 2'd0;
                end
            endcase
        end
    end

    // Stall counter survives flush; only reset clears it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && stall_cnt != STALL_MAX) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule
